// File: rtl/hdmi_vid_timing_gen.sv
// Raster timing generator that aligns a framebuffer pixel stream to the HDMI/DVI raster.
// Optional colour-bar source is compiled in with `define VTG_TEST_PATTERN_EN (adds pattern_sel).
module hdmi_vid_timing_gen #(
  parameter int C_DATA_WIDTH = 24,
  parameter int H_ACTIVE     = 1280,
  parameter int H_FP         = 110,
  parameter int H_SYNC       = 40,
  parameter int H_BP         = 220,
  parameter int V_ACTIVE     = 720,
  parameter int V_FP         = 5,
  parameter int V_SYNC       = 5,
  parameter int V_BP         = 20,
  parameter bit HS_POL       = 1'b1,
  parameter bit VS_POL       = 1'b1
) (
  input  logic                    pix_clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [C_DATA_WIDTH-1:0] s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tuser,
`ifdef VTG_TEST_PATTERN_EN
  input  logic                    pattern_sel,
`endif
  output logic [C_DATA_WIDTH-1:0] pix_data,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    vde,
  output logic                    frame_start,
  output logic                    underflow,
  output logic                    locked
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

  state_t                  state_q, state_d;
  logic [HW-1:0]           h_q, h_d;
  logic [VW-1:0]           v_q, v_d;
  logic                    sof_vld_q, sof_vld_d;
  logic [C_DATA_WIDTH-1:0] sof_data_q, sof_data_d;
  logic                    uf_pend_q, uf_pend_d;
  logic [C_DATA_WIDTH-1:0] pix_q, pix_d;
  logic                    hs_q, hs_d, vs_q, vs_d, vde_q, vde_d, fs_q, fs_d;
  logic                    uf_q, uf_d, lock_q, lock_d, rdy_q, rdy_d;

  logic running, active, at_first, at_last, fire, pat;

  assign running  = (state_q != IDLE);
  assign active   = running && (h_q < H_ACT) && (v_q < V_ACT);
  assign at_first = (h_q == '0) && (v_q == '0);
  assign at_last  = (h_q == H_LAST) && (v_q == V_LAST);
  assign fire     = s_tvalid && rdy_q && !pat;

`ifdef VTG_TEST_PATTERN_EN
  localparam int CW = C_DATA_WIDTH / 3;
  logic [2:0]              bar;
  logic [C_DATA_WIDTH-1:0] bar_rgb;
  assign pat     = pattern_sel;
  assign bar     = 3'((32'(h_q) * 8) / H_ACTIVE);
  // bar index bits map straight onto R/G/B on-off for the white..black sequence
  assign bar_rgb = C_DATA_WIDTH'({{CW{~bar[1]}}, {CW{~bar[2]}}, {CW{~bar[0]}}});
`else
  assign pat = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    v_d        = v_q;
    sof_vld_d  = sof_vld_q;
    sof_data_d = sof_data_q;
    uf_pend_d  = uf_pend_q;
    uf_d       = uf_q;
    pix_d      = '0;
    hs_d       = (running && h_q >= HS_BEG && h_q < HS_END) ? HS_POL : ~HS_POL;
    vs_d       = (running && v_q >= VS_BEG && v_q < VS_END) ? VS_POL : ~VS_POL;
    vde_d      = active;
    fs_d       = running && at_first;

    if (running) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: state_d = ALIGN;
      ALIGN: begin
        if (fire && s_tuser) begin
          sof_vld_d  = 1'b1;
          sof_data_d = s_tdata;
        end
        if (sof_vld_d && at_last) state_d = RUN;
      end
      RUN: begin
        if (active && !pat) begin
          if (at_first && sof_vld_q) begin
            pix_d     = sof_data_q;
            sof_vld_d = 1'b0;
          end else if (fire) begin
            // misplaced SOF is kept as the next frame's head; a missing SOF beat is dropped
            if (s_tuser && !at_first) begin
              state_d    = ALIGN;
              sof_vld_d  = 1'b1;
              sof_data_d = s_tdata;
              uf_pend_d  = 1'b0;
            end else if (!s_tuser && at_first) begin
              state_d   = ALIGN;
              uf_pend_d = 1'b0;
            end else begin
              pix_d = s_tdata;
            end
          end else begin
            uf_d      = 1'b1;
            uf_pend_d = 1'b1;
          end
        end
        if (state_d == RUN && uf_pend_d && at_last) begin
          state_d   = ALIGN;
          uf_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef VTG_TEST_PATTERN_EN
    if (pat && active) pix_d = bar_rgb;
`endif

    // ready is registered, so it is computed for the position the counters move to
    rdy_d = 1'b0;
    if (!pat) begin
      if (state_d == ALIGN) begin
        rdy_d = !sof_vld_d;
      end else if (state_d == RUN) begin
        rdy_d = (h_d < H_ACT) && (v_d < V_ACT) &&
                !((h_d == '0) && (v_d == '0) && sof_vld_d);
      end
    end
    lock_d = (state_d == RUN) || pat;
  end

  always_ff @(posedge pix_clk) begin
    if (rst || !en) begin
      state_q    <= IDLE;
      h_q        <= '0;
      v_q        <= '0;
      sof_vld_q  <= 1'b0;
      sof_data_q <= '0;
      uf_pend_q  <= 1'b0;
      pix_q      <= '0;
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
      vde_q      <= 1'b0;
      fs_q       <= 1'b0;
      uf_q       <= 1'b0;
      lock_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      sof_vld_q  <= sof_vld_d;
      sof_data_q <= sof_data_d;
      uf_pend_q  <= uf_pend_d;
      pix_q      <= pix_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      vde_q      <= vde_d;
      fs_q       <= fs_d;
      uf_q       <= uf_d;
      lock_q     <= lock_d;
      rdy_q      <= rdy_d;
    end
  end

  assign pix_data    = pix_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign vde         = vde_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign locked      = lock_q;
  assign s_tready    = rdy_q;
endmodule

// File: tb/tb_hdmi_vid_timing_gen.sv
// Directed bench for hdmi_vid_timing_gen on a 7x6 raster with a scoreboard of stream beats.
// With VTG_TEST_PATTERN_EN defined a second 11x6 instance checks the colour bars.
module tb_hdmi_vid_timing_gen;
  localparam int W  = 24;
  localparam int HT = 7;
  localparam int VT = 6;
  localparam int FT = HT * VT;

  logic         pix_clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic [W-1:0] s_tdata;
  logic         s_tvalid, s_tuser, s_tready;
  logic [W-1:0] pix_data;
  logic         hsync, vsync, vde, frame_start, underflow, locked;

  always #5 pix_clk = ~pix_clk;

  hdmi_vid_timing_gen #(
    .C_DATA_WIDTH(W), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .pix_clk(pix_clk), .rst(rst), .en(en),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tuser(s_tuser),
`ifdef VTG_TEST_PATTERN_EN
    .pattern_sel(1'b0),
`endif
    .pix_data(pix_data), .hsync(hsync), .vsync(vsync), .vde(vde),
    .frame_start(frame_start), .underflow(underflow), .locked(locked)
  );

`ifdef VTG_TEST_PATTERN_EN
  logic [W-1:0] pix_p;
  logic         rdy_p, hs_p, vs_p, vde_p, fs_p, uf_p, lock_p;
  localparam logic [W-1:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  hdmi_vid_timing_gen #(
    .C_DATA_WIDTH(W), .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_pat (
    .pix_clk(pix_clk), .rst(rst), .en(en),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(rdy_p), .s_tuser(s_tuser),
    .pattern_sel(1'b1),
    .pix_data(pix_p), .hsync(hs_p), .vsync(vs_p), .vde(vde_p),
    .frame_start(fs_p), .underflow(uf_p), .locked(lock_p)
  );
`endif

  int           total = 0;
  int           bad = 0;
  int           pos = -1;
  int           k = 0;
  bit           inj = 1'b0;
  bit           uf_exp = 1'b0;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] beat_data(input int kk);
    return W'((kk / 12) * 256 + (kk % 12));
  endfunction

  function automatic bit act_at(input int p);
    return ((p % HT) < 4) && (((p / HT) % VT) < 3);
  endfunction

  task automatic drive_src();
    s_tdata = inj ? 24'hABCDEF : beat_data(k);
    s_tuser = inj ? 1'b1 : ((k % 12) == 0);
  endtask

  task automatic tick();
    bit fire, lk, tu, rst_s, en_s, first;
    logic [W-1:0] td, expd;
    int p;
    fire = s_tvalid && s_tready;
    lk = locked;
    tu = s_tuser;
    td = s_tdata;
    rst_s = rst;
    en_s = en;
    p = pos;
    @(posedge pix_clk);
    if (fire) begin
      if (inj) inj = 1'b0;
      else k++;
    end
    @(negedge pix_clk);
    drive_src();
    if (rst_s || !en_s || p < 0) begin
      chk("rst_hsync", hsync, 0);
      chk("rst_vsync", vsync, 0);
      chk("rst_vde", vde, 0);
      chk("rst_pix", pix_data, 0);
      chk("rst_fs", frame_start, 0);
      chk("rst_uf", underflow, 0);
      chk("rst_lock", locked, 0);
      chk("rst_rdy", s_tready, (rst_s || !en_s) ? 0 : 1);
      if (rst_s || !en_s) begin
        pos = -1;
        uf_exp = 1'b0;
        exp_q.delete();
      end else begin
        pos = 0;
      end
    end else begin
      chk("vde", vde, act_at(p));
      chk("hsync", hsync, (p % HT) == 5);
      chk("vsync", vsync, ((p / HT) % VT) == 4);
      chk("frame_start", frame_start, (p % FT) == 0);
      first = ((p % FT) == 0);
      expd = '0;
      if (lk && act_at(p)) begin
        if (fire && ((tu && !first) || (!tu && first))) begin
          if (tu) exp_q.push_back(td);
        end else if (fire) begin
          exp_q.push_back(td);
          expd = exp_q.pop_front();
        end else if (first && exp_q.size() > 0) begin
          expd = exp_q.pop_front();
        end else begin
          uf_exp = 1'b1;
        end
      end else if (fire && tu) begin
        exp_q.push_back(td);
      end
      chk("pix", pix_data, expd);
      chk("underflow", underflow, uf_exp);
      pos++;
      if (locked && !act_at(pos)) chk("rdy_blank", s_tready, 0);
`ifdef VTG_TEST_PATTERN_EN
      chk("pat_pix", pix_p, ((p % 11) < 8 && ((p / 11) % VT) < 3) ? BARS[p % 11] : 24'h0);
      chk("pat_rdy", rdy_p, 0);
      chk("pat_lock", lock_p, 1);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired pos=%0d", pos);
    $fatal(1, "watchdog");
  end

  initial begin
    s_tvalid = 1'b1;
    drive_src();
    rst = 1'b1;
    en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("fs_before_run", frame_start, 0);
    tick();
    chk("fs_first", frame_start, 1);
    while (pos < 3 * FT) tick();
    chk("locked_stream", locked, 1);
    chk("uf_clean", underflow, 0);

    while (pos % FT != 9) tick();
    s_tvalid = 1'b0;
    tick();
    s_tvalid = 1'b1;
    chk("uf_flag", underflow, 1);
    chk("uf_pix_zero", pix_data, 0);
    chk("uf_still_locked", locked, 1);
    while (pos % FT != 0) tick();
    chk("uf_unlock", locked, 0);
    repeat (FT) tick();
    chk("uf_relock", locked, 1);
    chk("uf_sticky", underflow, 1);
    repeat (FT) tick();

    while (pos % FT != 8) tick();
    inj = 1'b1;
    drive_src();
    tick();
    chk("sof_unlock", locked, 0);
    while (pos % FT != 1) tick();
    chk("sof_pix0", pix_data, 24'hABCDEF);
    chk("sof_relock", locked, 1);
    repeat (3 * FT) tick();

    while (pos % FT != 2) tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    chk("en_idle_lock", locked, 0);
    chk("en_uf_clear", underflow, 0);
    tick();
    chk("en_fs_restart", frame_start, 1);
    repeat (3 * FT) tick();
    chk("en_relock", locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
